dedbx_sched: RTL and testbench
==============================

# dedbx_sched

Round-robin scheduler that shares one bit-plane-XOR inverse (DBX decode) datapath among `NUM_REQ` decompressor lanes. Each lane presents a 256-bit bit-plane-XOR word over valid/ready. The scheduler grants one lane per cycle and drives the winning word through a DEDBX instance. It returns the 256-bit delta (`diff`) word, tagged with the lane index, on a registered valid/ready output. It sits between the lane-local bit-plane unpackers and the delta-to-value reconstruction stage.

## Interface
- `NUM_REQ`, 4: number of requesting lanes, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: lane-tag width. Derived; not overridden.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-lane word valid.
- `req_bpx_i`  in  256*NUM_REQ  lane k word at `[256*k+255 : 256*k]`; same bit order as DEDBX `bpx_i`.
- `req_ready_o`  out  NUM_REQ  per-lane accept; one-hot or zero.
- `diff_valid_o`  out  1  output word valid.
- `diff_o`  out  256  decoded delta word; DEDBX `diff_o` format.
- `diff_id_o`  out  ID_W  lane index that produced `diff_o`.
- `diff_ready_i`  in  1  downstream accept.

## Operation
- Transfer on any handshake occurs when valid and ready are both high at a rising edge.
- **Arbitration**
  - Register `last_q` (ID_W bits, reset to NUM_REQ-1) holds the last granted lane.
  - Search order is `last_q+1, last_q+2, ...`, wrapping modulo NUM_REQ. The first lane with valid high wins.
  - The arbiter is combinational and produces `grant` (one-hot) and `grant_id`.
- **Accept condition:** `accept = |req_valid_i & stage_free`.
  - `stage_free` is high when the entry stage is empty, or when it is being drained this cycle.
  - `req_ready_o = grant & {NUM_REQ{accept}}`.
  - `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not derive valid from ready.
- **last_q update:** `last_q <= grant_id` only on accept. No accept leaves the pointer unchanged.
- **Datapath:** the selected word feeds one DEDBX instance (pure combinational). The result and `grant_id` are captured in the output register (`diff_o`, `diff_id_o`, `diff_valid_o`).
- **Output register behaviour**
  - Loads on accept.
  - Clears `diff_valid_o` when `diff_valid_o & diff_ready_i & !accept`.
  - Holds otherwise.
  - `stage_free = !diff_valid_o | diff_ready_i` (full-throughput; no bubble on back-to-back).
- **Backpressure:** while `diff_valid_o=1` and `diff_ready_i=0`:
  - `diff_o` and `diff_id_o` are stable.
  - All `req_ready_o=0`.
- **Reset**
  - Values: `diff_valid_o=0`, `diff_o=0`, `diff_id_o=0`, `last_q=NUM_REQ-1`.
  - `req_ready_o` is forced to 0 while `rst=1`.
  - Reset mid-stream discards any held word, with no output handshake.
- **Ordering:** per-lane order is preserved. No word is duplicated or dropped.

## Timing
- Latency: word accepted at edge N appears on `diff_o` with `diff_valid_o=1` after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle when `diff_ready_i=1`.
- Fairness: a continuously valid lane waits at most NUM_REQ-1 accepts between grants.
- Simultaneous drain and accept in one cycle: the output register reloads. `diff_valid_o` stays 1.
- Single valid lane: it is granted every accept cycle regardless of `last_q`.

## Configuration
- Macro: `DEDBX_SCHED_S0REG_EN`.
- **Defined:** an extra pipeline stage sits between the arbiter and DEDBX.
  - Stage-0 register holds `bpx`, `id` and `valid`.
  - Stage-0 advances when stage 1 is free. `stage_free` refers to stage 0.
  - Latency becomes 2 cycles; throughput is still 1/cycle.
  - On stall, both stages hold and no ready is asserted until stage 0 frees.
  - Stage-0 valid resets to 0 and its data to 0.
- **Undefined:** single-stage behaviour as above, with latency 1.

## Test plan
- **Reset, then decode:** hold `rst` for 2 cycles with all lanes valid; `req_ready_o=0` and `diff_valid_o=0` throughout. Then lane 0 only, `bpx` with only bit 255 set → `diff_o[255:248]=8'h80`, all other bits 0, `diff_id_o=0`, 1 cycle later.
- **Column cascade:** lane 2, `bpx` with only bit 254 set → `diff_o[247:240]=8'hFF`, rest 0, `diff_id_o=2`. All-zero `bpx` → `diff_o=0`.
- **Round-robin:** all 4 lanes continuously valid, `diff_ready_i=1` → `diff_id_o` sequence 0,1,2,3,0,1,… with `diff_valid_o` high every cycle.
- **Backpressure:**
  - Stimulus: lanes 1 and 3 valid; `diff_ready_i=0` for 5 cycles after the first output.
  - Required during the stall: `diff_o`/`diff_id_o` stable at the lane-1 result and `req_ready_o=0`.
  - Required on release: lane 3 is output next, and no word is lost or duplicated.
- **Random soak:** random valid per lane and random `diff_ready_i` (50%) for 10k cycles → per-lane scoreboard matches a DEDBX reference model in order, and no lane waits more than 3 accepts.
- **Mid-stream reset:** reset asserted while `diff_valid_o=1` and stalled → next cycle `diff_valid_o=0` and `last_q` restarts so lane 0 wins first. Repeat all tests with `DEDBX_SCHED_S0REG_EN` defined, checking 2-cycle latency.

Source files
------------

// File: rtl/dedbx_sched.sv
// ---------------------------------------------------------------------------
// dedbx_sched : round-robin scheduler sharing one DEDBX decoder among lanes.
// Optional stage-0 register before the decoder: DEDBX_SCHED_S0REG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dedbx_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [256*NUM_REQ-1:0] req_bpx_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   diff_valid_o,
  output logic [255:0]           diff_o,
  output logic [ID_W-1:0]        diff_id_o,
  input  logic                   diff_ready_i
);

  // Word layout: 8 planes of 32 bits, MSB plane at [255:224], column j at
  // bit (255-32*plane-j). Column 0 is the base column and is stored raw; every
  // other column cascades the XOR from the MSB plane downward.
  function automatic logic [255:0] dedbx(input logic [255:0] bpx);
    logic [255:0] d;
    logic         acc;
    d   = '0;
    acc = 1'b0;
    for (int j = 0; j < 32; j++) begin
      acc = 1'b0;
      for (int q = 0; q < 8; q++) begin
        acc = bpx[255-32*q-j] ^ (acc & (j != 0));
        d[255-8*j-q] = acc;
      end
    end
    return d;
  endfunction

  logic [ID_W-1:0]    r_last;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [255:0]       w_sel_bpx;
  logic [255:0]       w_dec;
  logic               w_stage_free;
  logic               w_accept;

  // Walk from farthest to nearest so the nearest valid lane after r_last wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_grant    = '0;
    w_grant_id = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(r_last) + i) % NUM_REQ;
      if (req_valid_i[idx]) begin
        w_grant      = '0;
        w_grant[idx] = 1'b1;
        w_grant_id   = ID_W'(idx);
      end
    end
    w_sel_bpx = req_bpx_i[256*int'(w_grant_id) +: 256];
  end

`ifdef DEDBX_SCHED_S0REG_EN
  logic            r_s0_valid;
  logic [255:0]    r_s0_bpx;
  logic [ID_W-1:0] r_s0_id;
  logic            w_s1_free;

  assign w_s1_free    = !diff_valid_o || diff_ready_i;
  assign w_stage_free = !r_s0_valid || w_s1_free;
  assign w_dec        = dedbx(r_s0_bpx);
`else
  assign w_stage_free = !diff_valid_o || diff_ready_i;
  assign w_dec        = dedbx(w_sel_bpx);
`endif

  assign w_accept    = (|req_valid_i) && w_stage_free && !rst;
  assign req_ready_o = w_grant & {NUM_REQ{w_accept}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= ID_W'(NUM_REQ - 1);
      diff_valid_o <= 1'b0;
      diff_o       <= '0;
      diff_id_o    <= '0;
`ifdef DEDBX_SCHED_S0REG_EN
      r_s0_valid   <= 1'b0;
      r_s0_bpx     <= '0;
      r_s0_id      <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_last <= w_grant_id;
      end
`ifdef DEDBX_SCHED_S0REG_EN
      if (w_accept) begin
        r_s0_valid <= 1'b1;
        r_s0_bpx   <= w_sel_bpx;
        r_s0_id    <= w_grant_id;
      end else if (w_s1_free) begin
        r_s0_valid <= 1'b0;
      end
      if (w_s1_free && r_s0_valid) begin
        diff_valid_o <= 1'b1;
        diff_o       <= w_dec;
        diff_id_o    <= r_s0_id;
      end else if (diff_valid_o && diff_ready_i) begin
        diff_valid_o <= 1'b0;
      end
`else
      if (w_accept) begin
        diff_valid_o <= 1'b1;
        diff_o       <= w_dec;
        diff_id_o    <= w_grant_id;
      end else if (diff_valid_o && diff_ready_i) begin
        diff_valid_o <= 1'b0;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dedbx_sched.sv
// Testbench for dedbx_sched: directed scenarios plus a scoreboarded random soak.
`default_nettype none

module tb_dedbx_sched;
  localparam int N = 4;
`ifdef DEDBX_SCHED_S0REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [256*N-1:0] bpx = '0;
  logic [N-1:0]   req_ready;
  logic           diff_valid;
  logic [255:0]   diff;
  logic [1:0]     diff_id;
  logic           dready = 1'b1;

  int total = 0;
  int bad   = 0;

  dedbx_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_bpx_i(bpx), .req_ready_o(req_ready),
    .diff_valid_o(diff_valid), .diff_o(diff), .diff_id_o(diff_id),
    .diff_ready_i(dready)
  );

  always #5 clk = ~clk;

  // Reference decoder: plane bit of column j lives at 255-32*p-j; columns
  // other than 0 reconstruct bit q as the XOR of planes 0..q.
  function automatic logic [255:0] ref_dbx(input logic [255:0] b);
    logic [255:0] r;
    logic         x;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      for (int q = 0; q < 8; q++) begin
        x = 1'b0;
        if (j == 0) x = b[255-32*q];
        else for (int p = 0; p <= q; p++) x = x ^ b[255-32*p-j];
        r[255-8*j-q] = x;
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid = '0; dready = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = '1; bpx = {N{256'h1234}}; dready = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      settle;
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      total++;
      if (diff_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", diff_valid); end
      tick;
    end
    total++;
    if ({diff_id, diff} !== 258'h0) begin bad++; $display("FAIL reset_data got id=%0d diff=%h want 0", diff_id, diff); end
    rst = 1'b0; valid = '0;
  endtask

  task automatic test_decode;
    logic [255:0] w;
    w = '0; w[255] = 1'b1;
    bpx[255:0] = w; valid = 4'b0001;
    settle;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL decode_ready got=%b want=0001", req_ready); end
    tick; valid = '0;
    repeat (LAT - 1) tick;
    total++;
    if ({diff_valid, diff_id, diff} !== {1'b1, 2'd0, 8'h80, 248'h0})
      begin bad++; $display("FAIL decode_msb got v=%b id=%0d diff=%h want v=1 id=0 diff=80..0", diff_valid, diff_id, diff); end
  endtask

  task automatic test_cascade;
    logic [255:0] w;
    w = '0; w[254] = 1'b1;
    bpx[767:512] = w; valid = 4'b0100;
    settle;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL cascade_ready got=%b want=0100", req_ready); end
    tick; valid = '0;
    repeat (LAT - 1) tick;
    total++;
    if ({diff_valid, diff_id, diff} !== {1'b1, 2'd2, 8'h00, 8'hFF, 240'h0})
      begin bad++; $display("FAIL cascade_col1 got v=%b id=%0d diff=%h want v=1 id=2 diff=00ff..0", diff_valid, diff_id, diff); end
    bpx[767:512] = '0; valid = 4'b0100;
    tick; valid = '0;
    repeat (LAT - 1) tick;
    total++;
    if ({diff_valid, diff_id, diff} !== {1'b1, 2'd2, 256'h0})
      begin bad++; $display("FAIL cascade_zero got v=%b id=%0d diff=%h want v=1 id=2 diff=0", diff_valid, diff_id, diff); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [255:0] lw [N];
    int k;
    do_reset;
    for (int i = 0; i < N; i++) begin
      lw[i] = {8{$urandom}};
      bpx[256*i +: 256] = lw[i];
    end
    valid = '1; dready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle;
      total++;
      if (req_ready !== 4'(1 << (c % N))) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % N))); end
      tick;
      if (c >= LAT - 1) begin
        k = (c - LAT + 1) % N;
        total++;
        if ({diff_valid, diff_id, diff} !== {1'b1, 2'(k), ref_dbx(lw[k])})
          begin bad++; $display("FAIL rr_out c=%0d got v=%b id=%0d want v=1 id=%0d", c, diff_valid, diff_id, k); end
      end
    end
    valid = '0;
    repeat (3) tick;
  endtask

  task automatic test_backpressure;
    logic [255:0] lw1, lw3;
    logic [N-1:0] rdy;
    logic [1:0]   oid [8];
    logic [255:0] od  [8];
    int n, no;
    do_reset;
    lw1 = {8{$urandom}}; lw3 = {8{$urandom}};
    bpx[511:256] = lw1; bpx[1023:768] = lw3;
    valid = 4'b1010; dready = 1'b1;
    n = 0;
    while (!diff_valid && n < 8) begin
      settle; rdy = req_ready; tick; valid = valid & ~rdy; n++;
    end
    total++;
    if (diff_valid !== 1'b1) begin bad++; $display("FAIL bp_first_timeout got=%b want=1", diff_valid); end
    dready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle;
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready i=%0d got=%b want=0000", i, req_ready); end
      total++;
      if ({diff_valid, diff_id, diff} !== {1'b1, 2'd1, ref_dbx(lw1)})
        begin bad++; $display("FAIL bp_stall_hold i=%0d got v=%b id=%0d want v=1 id=1", i, diff_valid, diff_id); end
      rdy = req_ready; tick; valid = valid & ~rdy;
    end
    dready = 1'b1;
    no = 0;
    repeat (6) begin
      settle; rdy = req_ready;
      if (diff_valid && dready && no < 8) begin oid[no] = diff_id; od[no] = diff; no++; end
      tick; valid = valid & ~rdy;
    end
    total++;
    if (no != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", no); end
    total++;
    if ({oid[0], od[0]} !== {2'd1, ref_dbx(lw1)}) begin bad++; $display("FAIL bp_order0 got id=%0d want 1", oid[0]); end
    total++;
    if ({oid[1], od[1]} !== {2'd3, ref_dbx(lw3)}) begin bad++; $display("FAIL bp_order1 got id=%0d want 3", oid[1]); end
  endtask

  task automatic test_soak;
    logic [255:0] mem [N][16];
    int hd [N];
    int tl [N];
    int wt [N];
    logic [N-1:0] rdy, vb;
    logic         hs, gen;
    logic [1:0]   hid;
    logic [255:0] hdat;
    do_reset;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; wt[k] = 0; end
    for (int c = 0; c < 10040; c++) begin
      gen = (c < 10000);
      for (int k = 0; k < N; k++)
        if (!valid[k] && gen && $urandom_range(0, 1) == 1) begin
          valid[k] = 1'b1;
          bpx[256*k +: 256] = {8{$urandom}};
        end
      dready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      settle;
      rdy = req_ready; vb = valid; hs = diff_valid && dready; hid = diff_id; hdat = diff;
      tick;
      if (hs) begin
        total++;
        if (hd[hid] == tl[hid]) begin
          bad++; $display("FAIL soak_extra lane=%0d got an output with none pending", hid);
        end else if (hdat !== mem[hid][hd[hid] % 16]) begin
          bad++; $display("FAIL soak_data lane=%0d got=%h want=%h", hid, hdat, mem[hid][hd[hid] % 16]);
        end
        hd[hid]++;
      end
      for (int k = 0; k < N; k++) begin
        if (rdy[k]) begin
          mem[k][tl[k] % 16] = ref_dbx(bpx[256*k +: 256]);
          tl[k]++; wt[k] = 0; valid[k] = 1'b0;
        end else if (vb[k] && rdy != '0) begin
          wt[k]++;
          total++;
          if (wt[k] > N - 1) begin bad++; $display("FAIL soak_fair lane=%0d waited=%0d max=%0d", k, wt[k], N - 1); end
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (hd[k] != tl[k]) begin bad++; $display("FAIL soak_drain lane=%0d got=%0d want=%0d", k, hd[k], tl[k]); end
    end
  endtask

  task automatic test_midreset;
    logic [N-1:0] rdy;
    int n;
    do_reset;
    dready = 1'b0;
    bpx[511:256] = {8{$urandom}}; valid = 4'b0010;
    n = 0;
    while (!diff_valid && n < 8) begin
      settle; rdy = req_ready; tick; valid = valid & ~rdy; n++;
    end
    total++;
    if (diff_valid !== 1'b1) begin bad++; $display("FAIL mr_fill_timeout got=%b want=1", diff_valid); end
    valid = '1; rst = 1'b1;
    settle;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL mr_ready_in_rst got=%b want=0000", req_ready); end
    tick;
    total++;
    if (diff_valid !== 1'b0) begin bad++; $display("FAIL mr_flush got=%b want=0", diff_valid); end
    rst = 1'b0; dready = 1'b1;
    settle;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL mr_restart got=%b want=0001", req_ready); end
    tick;
    repeat (LAT - 1) tick;
    total++;
    if ({diff_valid, diff_id} !== 3'b100) begin bad++; $display("FAIL mr_first got v=%b id=%0d want v=1 id=0", diff_valid, diff_id); end
    valid = '0;
    repeat (4) tick;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_cascade;
    test_round_robin;
    test_backpressure;
    test_soak;
    test_midreset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
